vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate divider, horizontal/vertical counters and registered sync/blank decode.
// Define VGA_TIMING_FRAMECNT_EN to add the frame_cnt output and its counter.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 29,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned FRAME_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  output logic                        pix_tick,
  output logic                        hs,
  output logic                        vs,
  output logic                        display_en,
  output logic [$clog2(H_ACTIVE)-1:0] x_pos,
  output logic [$clog2(V_ACTIVE)-1:0] y_pos,
  output logic                        line_start,
  output logic                        frame_start
`ifdef VGA_TIMING_FRAMECNT_EN
  ,
  output logic [FRAME_W-1:0]          frame_cnt
`endif
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HC_W     = $clog2(H_TOTAL);
  localparam int unsigned VC_W     = $clog2(V_TOTAL);
  localparam int unsigned X_W      = $clog2(H_ACTIVE);
  localparam int unsigned Y_W      = $clog2(V_ACTIVE);
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  function automatic logic in_window(input int unsigned val, input int unsigned lo,
                                     input int unsigned hi);
    return (val >= lo) && (val < hi);
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [HC_W-1:0]  h_q, h_d;
  logic [VC_W-1:0]  v_q, v_d;
  logic             div_last, h_wrap, v_wrap, frame_wrap;

  logic             hs_q, vs_q, de_q, ls_q, fs_q;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic             hs_d, vs_d, de_d, ls_d, fs_d;
  logic [X_W-1:0]   x_d;
  logic [Y_W-1:0]   y_d;

  assign div_last   = (div_q == DIV_W'(CLK_DIV - 1));
  assign h_wrap     = (h_q == HC_W'(H_TOTAL - 1));
  assign v_wrap     = (v_q == VC_W'(V_TOTAL - 1));
  assign pix_tick   = en & div_last;
  assign frame_wrap = pix_tick & h_wrap & v_wrap;

  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (en) begin
      div_d = div_last ? '0 : div_q + 1'b1;
    end
    if (pix_tick) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Decode from the next counter values so outputs move on the same edge as the counters.
  always_comb begin
    de_d = in_window(32'(h_d), 0, H_ACTIVE) && in_window(32'(v_d), 0, V_ACTIVE);
    x_d  = de_d ? h_d[X_W-1:0] : '0;
    y_d  = de_d ? v_d[Y_W-1:0] : '0;
    hs_d = in_window(32'(h_d), HS_START, HS_END) ? HS_POL : ~HS_POL;
    vs_d = in_window(32'(v_d), VS_START, VS_END) ? VS_POL : ~VS_POL;
    ls_d = (h_d == '0);
    fs_d = (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= HC_W'(H_TOTAL - 1);
      v_q   <= VC_W'(V_TOTAL - 1);
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      if (pix_tick) begin
        hs_q <= hs_d;
        vs_q <= vs_d;
        de_q <= de_d;
        ls_q <= ls_d;
        fs_q <= fs_d;
        x_q  <= x_d;
        y_q  <= y_d;
      end
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign display_en  = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;

`ifdef VGA_TIMING_FRAMECNT_EN
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;

  // Counts every return to (0,0), including the first one after reset.
  assign fcnt_d = frame_wrap ? fcnt_q + 1'b1 : fcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign frame_cnt = fcnt_q;
`else
  logic unused_wrap;
  assign unused_wrap = frame_wrap;
`endif

endmodule
